// File: rtl/pdp1_alu_pkg.sv
// Shared definitions for the PDP-1 ALU multiplier and divider blocks.
package pdp1_alu_pkg;

  localparam int unsigned WORD_W = 18;          // word width including sign bit
  localparam int unsigned MAG_W  = WORD_W - 1;  // magnitude width
  localparam int unsigned PROD_W = 2 * MAG_W;   // product magnitude width

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  // Ones-complement magnitude; -0 (all ones) maps to zero.
  function automatic logic [MAG_W-1:0] ones_mag(input logic [WORD_W-1:0] word);
    return word[WORD_W-1] ? ~word[MAG_W-1:0] : word[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/pdp1_cpu_alu_mul.sv
// PDP-1 mul: shift-and-add magnitude multiplier, one multiplier bit per clock.
module pdp1_cpu_alu_mul
  import pdp1_alu_pkg::*;
(
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] mul_a,
  input  logic [WORD_W-1:0] mul_b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product_mag,
  output logic              product_neg
);

  alu_state_e        state_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] mcand_q;
  logic [MAG_W-1:0]  mplier_q;
  logic [4:0]        count_q;
  logic              sign_q;
  logic              busy_q;
  logic              done_q;
  logic [PROD_W-1:0] product_mag_q;
  logic              product_neg_q;
  logic [PROD_W-1:0] acc_sum;

  // Accumulator value after the current multiplier bit is applied.
  always_comb begin
    acc_sum = acc_q;
    if (mplier_q[0]) acc_sum = acc_q + mcand_q;
  end

  // Sequencer FSM and datapath; outputs only load on the edge entering DONE.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      sign_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      product_mag_q <= '0;
      product_neg_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= {{(PROD_W - MAG_W){1'b0}}, ones_mag(mul_a)};
            mplier_q <= ones_mag(mul_b);
            sign_q   <= mul_a[WORD_W-1] ^ mul_b[WORD_W-1];
            acc_q    <= '0;
            count_q  <= 5'd16;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_sum;
          mcand_q  <= {mcand_q[PROD_W-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[MAG_W-1:1]};
          if (count_q == 5'd0) begin
            product_mag_q <= acc_sum;
            product_neg_q <= sign_q;
            done_q        <= 1'b1;
            state_q       <= StDone;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign product_mag = product_mag_q;
  assign product_neg = product_neg_q;

endmodule

// File: tb/tb_pdp1_cpu_alu_mul.sv
// Scoreboard bench for pdp1_cpu_alu_mul: driver queues expectations, monitor checks on done.
module tb_pdp1_cpu_alu_mul;

  logic        in_clock;
  logic        in_reset;
  logic        start;
  logic [17:0] mul_a;
  logic [17:0] mul_b;
  logic        busy;
  logic        done;
  logic [33:0] product_mag;
  logic        product_neg;

  typedef struct {
    logic [33:0] mag;
    logic        neg;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_vec;
  int          n_err;
  logic [33:0] last_mag;
  logic        last_neg;

  pdp1_cpu_alu_mul dut (
    .in_clock    (in_clock),
    .in_reset    (in_reset),
    .start       (start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .busy        (busy),
    .done        (done),
    .product_mag (product_mag),
    .product_neg (product_neg)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  // Count rising edges; an accept on the next edge gets index cyc+1.
  always @(posedge in_clock) cyc <= cyc + 1;

  // Monitor: check results on done, and output stability while running.
  always @(negedge in_clock) begin
    if (!in_reset) begin
      if (done) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_done: done=1 required no done pulse");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (product_mag !== e.mag || product_neg !== e.neg || busy !== 1'b1
              || cyc != e.cyc + 17) begin
            n_err++;
            $display("FAIL result: got mag=%h neg=%b busy=%b cyc=%0d, want mag=%h neg=%b busy=1 cyc=%0d",
                     product_mag, product_neg, busy, cyc, e.mag, e.neg, e.cyc + 17);
          end
          last_mag = e.mag;
          last_neg = e.neg;
        end
      end else if (busy) begin
        n_vec++;
        if (product_mag !== last_mag || product_neg !== last_neg) begin
          n_err++;
          $display("FAIL run_stable: got mag=%h neg=%b, want mag=%h neg=%b",
                   product_mag, product_neg, last_mag, last_neg);
        end
      end
    end
  end

  task automatic issue(input logic [17:0] a, input logic [17:0] b,
                       input logic [33:0] emag, input logic eneg);
    exp_t e;
    @(negedge in_clock);
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    e.mag = emag;
    e.neg = eneg;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge in_clock);
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    mul_a = 18'($urandom);
    mul_b = 18'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge in_clock);
      n++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    @(negedge in_clock);
  endtask

  initial begin
    cyc      = 0;
    n_vec    = 0;
    n_err    = 0;
    last_mag = '0;
    last_neg = 1'b0;
    start    = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    in_reset = 1'b1;
    repeat (2) @(negedge in_clock);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product_mag !== 34'h0 || product_neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b mag=%h neg=%b, want all zero",
               busy, done, product_mag, product_neg);
    end
    in_reset = 1'b0;
    @(negedge in_clock);

    issue(18'h00003, 18'h00005, 34'h00000000F, 1'b0); drain();
    issue(18'h1FFFF, 18'h1FFFF, 34'h3FFFC0001, 1'b0); drain();
    issue(18'h3FFFC, 18'h00005, 34'h00000000F, 1'b1); drain();
    issue(18'h00005, 18'h3FFFC, 34'h00000000F, 1'b1); drain();
    issue(18'h3FFFF, 18'h00007, 34'h000000000, 1'b1); drain();
    issue(18'h3FFFE, 18'h3FFFE, 34'h000000001, 1'b0); drain();
    issue(18'h0ABCD, 18'h00100, 34'h000ABCD00, 1'b0); drain();

    // Start re-asserted during RUN with other operands is ignored.
    issue(18'h00010, 18'h00021, 34'h000000210, 1'b0);
    repeat (3) @(negedge in_clock);
    mul_a = 18'h00002;
    mul_b = 18'h00002;
    start = 1'b1;
    repeat (2) @(negedge in_clock);
    start = 1'b0;
    drain();
    // A stray second done would be flagged by the monitor.
    repeat (25) @(negedge in_clock);

    // Reset in the middle of RUN aborts with no done.
    issue(18'h00007, 18'h00009, 34'h00000003F, 1'b0);
    repeat (7) @(negedge in_clock);
    #2 in_reset = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product_mag !== 34'h0 || product_neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: busy=%b done=%b mag=%h neg=%b, want all zero",
               busy, done, product_mag, product_neg);
    end
    sb.delete();
    last_mag = '0;
    last_neg = 1'b0;
    @(negedge in_clock);
    in_reset = 1'b0;
    repeat (25) @(negedge in_clock);
    issue(18'h00007, 18'h3FFF6, 34'h00000003F, 1'b1); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
